// File: rtl/otter_iobus_responder.sv
// IOBUS peripheral for the OTTER MCU: LED register, synchronised switches and
// a prescaled countdown timer that raises INTR on expiry.
module otter_iobus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic        INTR
);

  localparam logic [31:0] A_SW     = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_LED    = BASE_ADDR + 32'h20;
  localparam logic [31:0] A_TCTRL  = BASE_ADDR + 32'h40;
  localparam logic [31:0] A_TLOAD  = BASE_ADDR + 32'h44;
  localparam logic [31:0] A_TCOUNT = BASE_ADDR + 32'h48;
  localparam logic [31:0] A_TSTAT  = BASE_ADDR + 32'h4C;

  localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [15:0] sw_meta, sw_sync;
  logic [15:0] led;
  logic        auto_rl, ie, exp;
  logic [31:0] tload, tcount;
  logic [15:0] pre;
  logic        tick;

  logic wr_led, wr_tctrl, wr_tload, wr_tstat;

  assign wr_led   = IOBUS_WR && (IOBUS_ADDR == A_LED);
  assign wr_tctrl = IOBUS_WR && (IOBUS_ADDR == A_TCTRL);
  assign wr_tload = IOBUS_WR && (IOBUS_ADDR == A_TLOAD);
  assign wr_tstat = IOBUS_WR && (IOBUS_ADDR == A_TSTAT);

  assign tick = (state == RUN) && (pre == PRE_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      led     <= '0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      exp     <= 1'b0;
      tload   <= '0;
      tcount  <= '0;
      pre     <= '0;
    end else begin
      if (wr_led)   led   <= IOBUS_OUT[15:0];
      if (wr_tload) tload <= IOBUS_OUT;
      if (wr_tctrl) begin
        auto_rl <= IOBUS_OUT[1];
        ie      <= IOBUS_OUT[2];
      end
      // clear first so an expiry on the same edge overrides it
      if (wr_tstat && IOBUS_OUT[0]) exp <= 1'b0;

      case (state)
        IDLE: begin
          pre <= '0;
          if (wr_tctrl && IOBUS_OUT[0]) begin
            tcount <= tload;
            state  <= RUN;
          end
        end
        default: begin
          if (wr_tctrl && !IOBUS_OUT[0]) begin
            state <= IDLE;
            pre   <= '0;
          end else if (tick) begin
            pre <= '0;
            if (tcount != 32'd0) begin
              tcount <= tcount - 32'd1;
            end else begin
              exp <= 1'b1;
              if (auto_rl) tcount <= tload;
              else         state  <= IDLE;
            end
          end else begin
            pre <= pre + 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    IOBUS_IN = 32'd0;
    if (!RST) begin
      case (IOBUS_ADDR)
        A_SW:     IOBUS_IN = {16'd0, sw_sync};
        A_LED:    IOBUS_IN = {16'd0, led};
        A_TCTRL:  IOBUS_IN = {29'd0, ie, auto_rl, state == RUN};
        A_TLOAD:  IOBUS_IN = tload;
        A_TCOUNT: IOBUS_IN = tcount;
        A_TSTAT:  IOBUS_IN = {31'd0, exp};
        default:  IOBUS_IN = 32'd0;
      endcase
    end
  end

  assign LEDS = led;
  assign INTR = exp & ie;

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Bench for otter_iobus_responder: a PRESCALE=1 and a PRESCALE=4 instance share
// the bus; timer expectations come from tick arithmetic, registers from a scoreboard.
`timescale 1ns/1ps
module tb_otter_iobus_responder;

  localparam logic [31:0] B = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        wr = 1'b0;
  logic [15:0] sw = '0;
  logic [31:0] in_a, in_b;
  logic [15:0] leds_a, leds_b;
  logic        intr_a, intr_b;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  otter_iobus_responder #(.BASE_ADDR(B), .PRESCALE(1)) dut_a (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(in_a), .SWITCHES(sw), .LEDS(leds_a), .INTR(intr_a));

  otter_iobus_responder #(.BASE_ADDR(B), .PRESCALE(4)) dut_b (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(in_b), .SWITCHES(sw), .LEDS(leds_b), .INTR(intr_b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] ya, output logic [31:0] yb);
    addr = a; #1;
    ya = in_a; yb = in_b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ya, yb;
    logic [31:0] regs [5];
    regs = '{B + 32'h40, B + 32'h44, B + 32'h48, B + 32'h4C, B + 32'h10};
    rd(B + 32'h20, ya, yb);
    checks++; if (ya !== 32'd0 || leds_a !== 16'd0 || intr_a !== 1'b0) begin
      errors++; $display("FAIL reset_hold: in=%h leds=%h intr=%b want 0", ya, leds_a, intr_a); end
    @(negedge clk); rst = 1'b0;
    bus_write(B + 32'h20, 32'h0000_FFFF);
    bus_write(B + 32'h44, 32'd0);
    bus_write(B + 32'h40, 32'b111);
    tick(); tick();
    checks++; if (intr_a !== 1'b1 || leds_a !== 16'hFFFF) begin
      errors++; $display("FAIL reset_pre: intr=%b leds=%h want 1 ffff", intr_a, leds_a); end
    #3 rst = 1'b1; #1;
    checks++; if (leds_a !== 16'd0 || intr_a !== 1'b0) begin
      errors++; $display("FAIL reset_async: leds=%h intr=%b want 0 0", leds_a, intr_a); end
    rd(B + 32'h20, ya, yb);
    checks++; if (ya !== 32'd0) begin
      errors++; $display("FAIL reset_read: got %h want 0", ya); end
    @(negedge clk); rst = 1'b0;
    foreach (regs[i]) begin
      rd(regs[i], ya, yb);
      checks++; if (ya !== 32'd0) begin
        errors++; $display("FAIL reset_reg %h: got %h want 0", regs[i], ya); end
    end
  endtask

  task automatic test_led_switch();
    logic [31:0] ya, yb;
    bus_write(B + 32'h20, 32'h0001_ABCD);
    rd(B + 32'h20, ya, yb);
    checks++; if (leds_a !== 16'hABCD || ya !== 32'h0000_ABCD) begin
      errors++; $display("FAIL led_rw: leds=%h rd=%h want abcd 0000abcd", leds_a, ya); end
    @(negedge clk); sw = 16'h5A5A;
    tick();
    rd(B, ya, yb);
    checks++; if (ya !== 32'd0) begin
      errors++; $display("FAIL sw_sync1: got %h want 0", ya); end
    tick();
    rd(B, ya, yb);
    checks++; if (ya !== 32'h0000_5A5A) begin
      errors++; $display("FAIL sw_sync2: got %h want 00005a5a", ya); end
  endtask

  task automatic test_oneshot();
    logic [31:0] ya, yb;
    do_reset();
    bus_write(B + 32'h44, 32'd3);
    bus_write(B + 32'h40, 32'b101);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      rd(B + 32'h48, ya, yb);
      checks++; if (ya !== 32'(3 - k) || intr_a !== 1'b0) begin
        errors++; $display("FAIL oneshot_cnt%0d: cnt=%h intr=%b want %h 0", k, ya, intr_a, 3 - k); end
    end
    tick();
    rd(B + 32'h4C, ya, yb);
    checks++; if (intr_a !== 1'b1 || ya !== 32'd1) begin
      errors++; $display("FAIL oneshot_exp: intr=%b tstat=%h want 1 1", intr_a, ya); end
    rd(B + 32'h40, ya, yb);
    checks++; if (ya !== 32'b100) begin
      errors++; $display("FAIL oneshot_ctrl: got %h want 4", ya); end
    tick(); tick(); tick();
    rd(B + 32'h48, ya, yb);
    checks++; if (ya !== 32'd0 || intr_a !== 1'b1) begin
      errors++; $display("FAIL oneshot_hold: cnt=%h intr=%b want 0 1", ya, intr_a); end
  endtask

  task automatic test_auto_reload();
    do_reset();
    bus_write(B + 32'h44, 32'd2);
    bus_write(B + 32'h40, 32'b111);
    tick(); tick();
    checks++; if (intr_a !== 1'b0) begin
      errors++; $display("FAIL auto_pre: intr=%b want 0", intr_a); end
    tick();
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL auto_exp1: intr=%b want 1", intr_a); end
    bus_write(B + 32'h4C, 32'd1);
    checks++; if (intr_a !== 1'b0) begin
      errors++; $display("FAIL auto_clr: intr=%b want 0", intr_a); end
    tick();
    checks++; if (intr_a !== 1'b0) begin
      errors++; $display("FAIL auto_gap: intr=%b want 0", intr_a); end
    tick();
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL auto_exp2: intr=%b want 1", intr_a); end
    tick(); tick();
    bus_write(B + 32'h4C, 32'd1);
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL w1c_vs_exp: intr=%b want 1", intr_a); end
    bus_write(B + 32'h4C, 32'd0);
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL w0_noeffect: intr=%b want 1", intr_a); end
  endtask

  task automatic test_tload_during_run();
    do_reset();
    bus_write(B + 32'h44, 32'd2);
    bus_write(B + 32'h40, 32'b111);
    bus_write(B + 32'h44, 32'd10);
    tick();
    checks++; if (intr_a !== 1'b0) begin
      errors++; $display("FAIL tload_run_pre: intr=%b want 0", intr_a); end
    tick();
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL tload_run_exp: intr=%b want 1", intr_a); end
    bus_write(B + 32'h4C, 32'd1);
    for (int k = 2; k <= 10; k++) tick();
    checks++; if (intr_a !== 1'b0) begin
      errors++; $display("FAIL tload_run_early: intr=%b want 0", intr_a); end
    tick();
    checks++; if (intr_a !== 1'b1) begin
      errors++; $display("FAIL tload_run_period: intr=%b want 1", intr_a); end
  endtask

  task automatic test_prescale();
    logic [31:0] ya, yb;
    int early;
    do_reset();
    bus_write(B + 32'h44, 32'd1);
    bus_write(B + 32'h40, 32'b101);
    early = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (intr_b !== 1'b0) early++;
    end
    checks++; if (early != 0) begin
      errors++; $display("FAIL prescale_early: %0d cycles high want 0", early); end
    tick();
    checks++; if (intr_b !== 1'b1) begin
      errors++; $display("FAIL prescale_exp: intr=%b want 1", intr_b); end
    bus_write(B + 32'h40, 32'b000);
    rd(B + 32'h4C, ya, yb);
    checks++; if (yb !== 32'd1 || intr_b !== 1'b0) begin
      errors++; $display("FAIL ie_mask: tstat=%h intr=%b want 1 0", yb, intr_b); end
  endtask

  task automatic test_random_regs();
    logic [31:0] ya, yb, a, d;
    logic [15:0] led_m;
    logic [31:0] tload_m;
    logic [31:0] junk [5];
    junk = '{B + 32'h10, B + 32'h21, B + 32'h50, B + 32'h1000_0020, B + 32'h48};
    do_reset();
    led_m = '0; tload_m = '0;
    for (int n = 0; n < 30; n++) begin
      d = $urandom;
      case ($urandom_range(0, 2))
        0: begin bus_write(B + 32'h20, d); led_m = d[15:0]; end
        1: begin bus_write(B + 32'h44, d); tload_m = d; end
        default: bus_write(junk[$urandom_range(0, 4)], d);
      endcase
      case ($urandom_range(0, 3))
        0: begin a = B + 32'h20; d = {16'd0, led_m}; end
        1: begin a = B + 32'h44; d = tload_m; end
        2: begin a = B + 32'h48; d = 32'd0; end
        default: begin a = junk[$urandom_range(0, 3)]; d = 32'd0; end
      endcase
      rd(a, ya, yb);
      checks++; if (ya !== d || yb !== d || leds_a !== led_m) begin
        errors++; $display("FAIL rand_reg %h: got %h/%h leds %h want %h leds %h", a, ya, yb, leds_a, d, led_m); end
    end
  endtask

  task automatic test_random_timer();
    logic [31:0] ya, yb, ea, eb;
    int l, ta, tb, bad;
    for (int trial = 0; trial < 3; trial++) begin
      do_reset();
      l = $urandom_range(0, 5);
      bus_write(B + 32'h44, 32'(l));
      bus_write(B + 32'h40, 32'b111);
      bad = 0;
      for (int k = 0; k <= 30; k++) begin
        if (k > 0) tick();
        ta = k; tb = k / 4;
        ea = 32'(l - (ta % (l + 1)));
        eb = 32'(l - (tb % (l + 1)));
        rd(B + 32'h48, ya, yb);
        if (ya !== ea || yb !== eb || intr_a !== (ta >= l + 1) || intr_b !== (tb >= l + 1)) begin
          bad++;
          if (bad == 1) $display("FAIL rand_timer L=%0d k=%0d: cnt %0d/%0d intr %b/%b want %0d/%0d %b/%b",
                                 l, k, ya, yb, intr_a, intr_b, ea, eb, ta >= l + 1, tb >= l + 1);
        end
      end
      checks++; if (bad != 0) errors++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #5;
    test_reset();
    test_led_switch();
    test_oneshot();
    test_auto_reload();
    test_tload_during_run();
    test_prescale();
    test_random_regs();
    test_random_timer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
